// File: rtl/cmp_lt_arbiter.sv
// cmp_lt_arbiter: round-robin arbiter sharing one signed less-than comparator behind an operand/result pipeline
module cmp_lt_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 32,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_lt,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       cmp_count
);
  logic op_vld, found, adv0, adv1, acc;
  logic [W-1:0] op_a, op_b, sel_a, sel_b;
  logic [IDW-1:0] op_id, rr_ptr, g;
  int idx;
  assign adv1 = !rsp_valid | rsp_ready;
  assign adv0 = !op_vld | adv1;
  always_comb begin
    found = 1'b0;
    g = '0;
    sel_a = '0;
    sel_b = '0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g = IDW'(idx);
        sel_a = req_a[idx*W +: W];
        sel_b = req_b[idx*W +: W];
      end
    end
  end
  // reset gates the grant so req_ready drops the moment rst_n falls
  assign acc = found & adv0 & rst_n;
  assign req_ready = acc ? NREQ'(1) << g : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      op_id <= '0;
      rr_ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_lt <= 1'b0;
      rsp_id <= '0;
      cmp_count <= '0;
    end else begin
      if (adv0) begin
        op_vld <= acc;
        if (acc) begin
          op_a <= sel_a;
          op_b <= sel_b;
          op_id <= g;
          rr_ptr <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
        end
      end
      if (adv1) begin
        rsp_valid <= op_vld;
        if (op_vld) begin
          rsp_lt <= $signed(op_a) < $signed(op_b);
          rsp_id <= op_id;
        end
      end
      if (rsp_valid && rsp_ready) cmp_count <= cmp_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_cmp_lt_arbiter.sv
// tb_cmp_lt_arbiter: directed tables and randomized traffic checked against a queue-based reference model
module tb_cmp_lt_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_lt;
  logic [1:0] rsp_id;
  logic [15:0] cmp_count;
  cmp_lt_arbiter #(.NREQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lt(rsp_lt), .rsp_id(rsp_id), .cmp_count(cmp_count)
  );
  always #5 clk = ~clk;
  typedef struct {logic lt; int id; int age;} item_t;
  typedef struct {logic [31:0] a; logic [31:0] b; logic lt;} vec_t;
  item_t q[$];
  vec_t tab[4];
  logic [W-1:0] ma[N], mb[N];
  logic [15:0] mcount, c0;
  int rr, hs, vectors, miscompares, dut_grant, n;
  int exp_f[3];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'h7fff_ffff;
      2: return 32'hffff_ffff;
      default: return $urandom();
    endcase
  endfunction
  task automatic model_reset();
    q.delete();
    rr = 0;
    mcount = '0;
    hs = 0;
  endtask
  // one clock: drive at negedge, compare against the model, then advance the model past the posedge
  task automatic step(input logic [N-1:0] v, input logic r);
    int g;
    logic can, ev;
    logic [N-1:0] er;
    @(negedge clk);
    req_valid = v;
    rsp_ready = r;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ma[i];
      req_b[i*W +: W] = mb[i];
    end
    #1;
    can = q.size() < 2 || r;
    g = -1;
    for (int k = N - 1; k >= 0; k--) if (v[(rr + k) % N]) g = (rr + k) % N;
    er = '0;
    if (g >= 0 && can) er[g] = 1'b1;
    ev = q.size() > 0 && q[0].age >= 2;
    dut_grant = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_grant = i;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      chk("rsp_lt", 32'(rsp_lt), 32'(q[0].lt));
      chk("rsp_id", 32'(rsp_id), q[0].id);
    end
    chk("cmp_count", 32'(cmp_count), 32'(mcount));
    @(posedge clk);
    if (ev && r) begin
      void'(q.pop_front());
      mcount++;
      hs++;
    end
    foreach (q[i]) q[i].age++;
    if (er != 0) begin
      q.push_back('{$signed(ma[g]) < $signed(mb[g]), g, 1});
      rr = (g + 1) % N;
      ma[g] = rnd32();
      mb[g] = ($urandom_range(0, 5) == 0) ? ma[g] : rnd32();
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask
  initial begin
    vectors = 0;
    miscompares = 0;
    tab = '{'{32'h8000_0000, 32'h7fff_ffff, 1'b1}, '{32'hffff_ffff, 32'h0000_0000, 1'b1},
            '{32'h0000_0005, 32'h0000_0005, 1'b0}, '{32'h7fff_ffff, 32'h8000_0000, 1'b0}};
    exp_f = '{3, 0, 3};
    for (int i = 0; i < N; i++) begin
      ma[i] = rnd32();
      mb[i] = rnd32();
    end
    model_reset();
    #2;
    req_valid = '1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_cmp_count", 32'(cmp_count), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_lt", 32'(rsp_lt), 0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ma[0] = tab[i].a;
      mb[0] = tab[i].b;
      step(4'b0001, 1'b1);
      step(4'b0000, 1'b1);
      #1;
      chk("bnd_valid", 32'(rsp_valid), 1);
      chk("bnd_lt", 32'(rsp_lt), 32'(tab[i].lt));
      chk("bnd_id", 32'(rsp_id), 0);
    end
    step(4'b0000, 1'b1);
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(4'b1111, 1'b1);
      chk("rr_grant", dut_grant, k % 4);
    end
    do_reset();
    step(4'b0001, 1'b1);
    chk("fair_first", dut_grant, 0);
    for (int k = 0; k < 3; k++) begin
      step(4'b1001, 1'b1);
      chk("fair_grant", dut_grant, exp_f[k]);
    end
    repeat (3) step(4'b0000, 1'b1);
    #1;
    c0 = cmp_count;
    n = 0;
    repeat (5) begin
      step(4'b0100, 1'b0);
      if (dut_grant == 2) n++;
    end
    chk("bp_accepts", n, 2);
    repeat (4) step(4'b0000, 1'b1);
    #1;
    chk("bp_empty", 32'(rsp_valid), 0);
    chk("bp_handshakes", 32'(cmp_count - c0), 2);
    repeat (3000) step(N'($urandom()), $urandom_range(0, 3) != 0);
    repeat (3) step(4'b1111, 1'b0);
    #2;
    chk("full_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_count", 32'(cmp_count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0110, 1'b1);
    chk("post_rst_grant", dut_grant, 1);
    do_reset();
    while (hs < 65536) step(4'b1111, 1'b1);
    #1;
    chk("wrap", 32'(cmp_count), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
